// File: rtl/sid_tdm_sched_if.sv
// sid_tdm_sched_if: bundle between the SID array environment and the TDM scheduler.
// The slave modport is the scheduler; master is the voices/tables/filter side.
interface sid_tdm_sched_if #(
    parameter int CHIPS = 2,
    parameter int AW    = 18
);
    logic                        ce_1m;
    logic [CHIPS*36-1:0]         acc_t;
    logic [CHIPS*2-1:0]          pan;
    logic [11:0]                 tbl_acc_t;
    logic [2:0]                  tbl_chip;
    logic [7:0]                  tbl_st;
    logic [7:0]                  tbl_pt;
    logic [7:0]                  tbl_ps;
    logic [7:0]                  tbl_pst;
    logic [CHIPS*24-1:0]         wave_st;
    logic [CHIPS*24-1:0]         wave_pt;
    logic [CHIPS*24-1:0]         wave_ps;
    logic [CHIPS*24-1:0]         wave_pst;
    logic [2:0]                  flt_chip;
    logic [2:0]                  flt_state;
    logic signed [AW-1:0]        flt_audio;
    logic [CHIPS*AW-1:0]         audio;
    logic signed [AW-1:0]        mix_l;
    logic signed [AW-1:0]        mix_r;
    logic                        busy;
    logic                        overrun;

    modport master (
        output ce_1m, acc_t, pan, tbl_st, tbl_pt, tbl_ps, tbl_pst, flt_audio,
        input  tbl_acc_t, tbl_chip, wave_st, wave_pt, wave_ps, wave_pst,
               flt_chip, flt_state, audio, mix_l, mix_r, busy, overrun
    );

    modport slave (
        input  ce_1m, acc_t, pan, tbl_st, tbl_pt, tbl_ps, tbl_pst, flt_audio,
        output tbl_acc_t, tbl_chip, wave_st, wave_pt, wave_ps, wave_pst,
               flt_chip, flt_state, audio, mix_l, mix_r, busy, overrun
    );
endinterface

// File: rtl/sid_tdm_sched.sv
// sid_tdm_sched: shares one waveform-table unit and one filter unit across CHIPS SID chips per ce_1m frame.
// Macro SID_TDM_PAN_EN enables per-chip panning; without it even chips mix left and odd chips mix right.
module sid_tdm_sched #(
    parameter int CHIPS   = 2,
    parameter int TBL_LAT = 2,
    parameter int AW      = 18
) (
    input  logic           clk,
    input  logic           reset,
    sid_tdm_sched_if.slave bus
);
    localparam int V  = 3 * CHIPS;
    localparam int B0 = V + TBL_LAT;
    localparam int C  = B0 + 8 * CHIPS;
    localparam int CW = $clog2(C + 2);
    localparam int SW = AW + 3;
    localparam logic [CW-1:0] CNT_IDLE = '1;
    localparam logic [CW-1:0] CNT_C    = CW'(C);
    localparam logic [CW-1:0] CNT_B0   = CW'(B0);
    localparam logic signed [SW-1:0] SAT_MAX = $signed({4'b0000, {(AW-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({4'b1111, {(AW-1){1'b0}}});

    function automatic logic signed [AW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[AW-1:0];
        else if (v < SAT_MIN) return SAT_MIN[AW-1:0];
        else                  return v[AW-1:0];
    endfunction

    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_overrun;
    logic [11:0]            r_tbl_acc_t;
    logic [2:0]             r_tbl_chip;
    logic [2:0]             r_flt_chip;
    logic [2:0]             r_flt_state;
    logic [CHIPS*24-1:0]    r_wave_st, r_wave_pt, r_wave_ps, r_wave_pst;
    logic [CHIPS*AW-1:0]    r_stage;
    logic [CHIPS*AW-1:0]    r_audio;
    logic signed [AW-1:0]   r_mix_l, r_mix_r;

    logic [CW-1:0]          w_cnt_nxt;
    logic [CW-1:0]          w_boff;
    logic [CHIPS-1:0]       w_l_en, w_r_en;
    logic signed [AW-1:0]   w_smp;
    logic signed [SW-1:0]   w_sum_l, w_sum_r;

    // Frame counter: ce_1m restarts, runs 0..C, then parks at all-ones
    always_comb begin
        w_cnt_nxt = CNT_IDLE;
        if (bus.ce_1m)          w_cnt_nxt = '0;
        else if (r_cnt < CNT_C) w_cnt_nxt = r_cnt + CW'(1);
    end
    assign w_boff = w_cnt_nxt - CNT_B0;

    // Stereo routing of committed chip samples
    always_comb begin
        w_l_en = '0;
        w_r_en = '0;
        for (int c = 0; c < CHIPS; c++) begin
`ifdef SID_TDM_PAN_EN
            w_l_en[c] = ~bus.pan[2*c+1];
            w_r_en[c] = ~bus.pan[2*c];
`else
            w_l_en[c] = (c % 2 == 0) || (CHIPS == 1);
            w_r_en[c] = (c % 2 == 1) || (CHIPS == 1);
`endif
        end
    end

`ifndef SID_TDM_PAN_EN
    logic w_unused_pan;
    assign w_unused_pan = ^bus.pan;
`endif

    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        w_smp   = '0;
        for (int c = 0; c < CHIPS; c++) begin
            w_smp = r_audio[c*AW +: AW];
            if (w_l_en[c]) w_sum_l = w_sum_l + $signed({{3{w_smp[AW-1]}}, w_smp});
            if (w_r_en[c]) w_sum_r = w_sum_r + $signed({{3{w_smp[AW-1]}}, w_smp});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= CNT_IDLE;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_tbl_acc_t <= '0;
            r_tbl_chip  <= '0;
            r_flt_chip  <= '0;
            r_flt_state <= 3'd7;
            r_wave_st   <= '0;
            r_wave_pt   <= '0;
            r_wave_ps   <= '0;
            r_wave_pst  <= '0;
            r_stage     <= '0;
            r_audio     <= '0;
            r_mix_l     <= '0;
            r_mix_r     <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (bus.ce_1m) begin
                r_busy <= 1'b1;
                if (r_busy) r_overrun <= 1'b1;
            end else if (r_cnt == CNT_C) begin
                r_audio <= r_stage;
                r_busy  <= 1'b0;
            end

            // Phase A: issue one voice per cycle, capture it TBL_LAT cycles later
            for (int k = 0; k < V; k++) begin
                if (w_cnt_nxt == CW'(k)) begin
                    r_tbl_acc_t <= bus.acc_t[k*12 +: 12];
                    r_tbl_chip  <= 3'(k / 3);
                end
                if (r_cnt == CW'(k + TBL_LAT)) begin
                    r_wave_st[k*8 +: 8]  <= bus.tbl_st;
                    r_wave_pt[k*8 +: 8]  <= bus.tbl_pt;
                    r_wave_ps[k*8 +: 8]  <= bus.tbl_ps;
                    r_wave_pst[k*8 +: 8] <= bus.tbl_pst;
                end
            end

            // Phase B: eight filter micro-steps per chip, output staged on step 6
            if (w_cnt_nxt >= CNT_B0 && w_cnt_nxt < CNT_C) begin
                r_flt_chip  <= 3'(w_boff >> 3);
                r_flt_state <= w_boff[2:0];
            end else begin
                r_flt_state <= 3'd7;
            end
            for (int c = 0; c < CHIPS; c++) begin
                if (r_flt_state == 3'd6 && r_flt_chip == 3'(c))
                    r_stage[c*AW +: AW] <= bus.flt_audio;
            end

            // Mix stage: follows committed audio by one cycle
            r_mix_l <= sat(w_sum_l);
            r_mix_r <= sat(w_sum_r);
        end
    end

    assign bus.tbl_acc_t = r_tbl_acc_t;
    assign bus.tbl_chip  = r_tbl_chip;
    assign bus.wave_st   = r_wave_st;
    assign bus.wave_pt   = r_wave_pt;
    assign bus.wave_ps   = r_wave_ps;
    assign bus.wave_pst  = r_wave_pst;
    assign bus.flt_chip  = r_flt_chip;
    assign bus.flt_state = r_flt_state;
    assign bus.audio     = r_audio;
    assign bus.mix_l     = r_mix_l;
    assign bus.mix_r     = r_mix_r;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
endmodule
